// File: rtl/dsc_pkg.sv
// dsc_pkg: shared DSC types for chroma layout and resampler configuration
package dsc_pkg;
    localparam int DSC_BPC_MAX = 12;
    localparam int DSC_DIM_BITS = 13;
    typedef enum logic [1:0] {
        CHROMA_444 = 2'd0,
        CHROMA_422 = 2'd1,
        CHROMA_420 = 2'd2
    } dsc_chroma_e;
    typedef struct packed {
        dsc_chroma_e chroma;
        logic alpha;
        logic [DSC_DIM_BITS-1:0] width;
        logic [DSC_DIM_BITS-1:0] height;
    } dsc_rs_cfg_s;
endpackage

// File: rtl/dsc_rs_out_reg.sv
// dsc_rs_out_reg: single valid/ready output stage holding one beat and its frame flags
module dsc_rs_out_reg #(
    parameter int BPC = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    output logic           ready,
    input  logic [BPC-1:0] y,
    input  logic [BPC-1:0] cb,
    input  logic [BPC-1:0] cr,
    input  logic [BPC-1:0] a,
    input  logic           c_valid,
    input  logic           sof,
    input  logic           eol,
    input  logic           eof,
    input  logic           m_ready,
    output logic           m_valid,
    output logic [BPC-1:0] m_y,
    output logic [BPC-1:0] m_cb,
    output logic [BPC-1:0] m_cr,
    output logic [BPC-1:0] m_a,
    output logic           m_c_valid,
    output logic           m_sof,
    output logic           m_eol,
    output logic           m_eof
);
    assign ready = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            {m_y, m_cb, m_cr, m_a} <= '0;
            {m_c_valid, m_sof, m_eol, m_eof} <= '0;
        end else if (ld) begin
            m_valid <= 1'b1;
            {m_y, m_cb, m_cr, m_a} <= {y, cb, cr, a};
            {m_c_valid, m_sof, m_eol, m_eof} <= {c_valid, sof, eol, eof};
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/dsc_chroma_resampler.sv
// dsc_chroma_resampler: streaming 4:4:4 to 4:4:4/4:2:2/4:2:0 chroma resampler with alpha pass-through
module dsc_chroma_resampler
    import dsc_pkg::*;
#(
    parameter int BPC = 12,
    parameter int NUM_COMP = 4,
    parameter int W_BITS = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              cfg_chroma,
    input  logic                    cfg_alpha,
    input  logic [W_BITS-1:0]       cfg_width,
    input  logic [W_BITS-1:0]       cfg_height,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [NUM_COMP*BPC-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BPC-1:0]          m_y,
    output logic [BPC-1:0]          m_cb,
    output logic [BPC-1:0]          m_cr,
    output logic                    m_c_valid,
    output logic [BPC-1:0]          m_a,
    output logic                    m_sof,
    output logic                    m_eol,
    output logic                    m_eof,
    output logic                    busy,
    output logic                    cfg_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0] state;
    dsc_rs_cfg_s cfg;
    logic [W_BITS-1:0] x, y, w_m1, h_m1;
    logic [BPC-1:0] hold_cb, hold_cr, c_y, c_cb, c_cr, c_a, o_cb, o_cr;
    logic [BPC:0] sum_cb, sum_cr;
    logic o_ready, acc, bad, last_x, last_y, sub, drop, c_valid;

    assign c_y = s_data[0 +: BPC];
    assign c_cb = s_data[BPC +: BPC];
    assign c_cr = s_data[2*BPC +: BPC];
    if (NUM_COMP == 4) begin : g_alpha
        assign c_a = cfg.alpha ? s_data[3*BPC +: BPC] : '0;
    end else begin : g_no_alpha
        assign c_a = '0;
    end

    assign busy = state == ACTIVE;
    assign s_ready = busy && o_ready;
    assign acc = s_valid && s_ready;
    assign bad = cfg_width == '0 || cfg_height == '0 || cfg_chroma == 2'd3;
    assign w_m1 = W_BITS'(cfg.width) - W_BITS'(1);
    assign h_m1 = W_BITS'(cfg.height) - W_BITS'(1);
    assign last_x = x == w_m1;
    assign last_y = y == h_m1;
    assign sub = cfg.chroma != CHROMA_444;
    assign drop = cfg.chroma == CHROMA_420 && y[0];
    // Even-x beats carry chroma only as the tail of an odd-width line
    assign c_valid = !sub ? 1'b1 : drop ? 1'b0 : x[0] ? 1'b1 : last_x;
    assign sum_cb = {1'b0, hold_cb} + {1'b0, c_cb} + (BPC+1)'(1);
    assign sum_cr = {1'b0, hold_cr} + {1'b0, c_cr} + (BPC+1)'(1);
    assign o_cb = (sub && x[0]) ? sum_cb[BPC:1] : c_cb;
    assign o_cr = (sub && x[0]) ? sum_cr[BPC:1] : c_cr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cfg <= '0;
            {x, y} <= '0;
            {hold_cb, hold_cr} <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= state == IDLE && start && bad;
            if (state == IDLE && start && !bad) begin
                state <= ACTIVE;
                cfg <= '{chroma: dsc_chroma_e'(cfg_chroma), alpha: cfg_alpha,
                         width: DSC_DIM_BITS'(cfg_width), height: DSC_DIM_BITS'(cfg_height)};
                {x, y} <= '0;
                {hold_cb, hold_cr} <= '0;
            end else if (acc) begin
                x <= last_x ? '0 : x + W_BITS'(1);
                y <= !last_x ? y : last_y ? '0 : y + W_BITS'(1);
                if (last_x && last_y) state <= IDLE;
                if (!x[0]) {hold_cb, hold_cr} <= {c_cb, c_cr};
            end
        end
    end

    dsc_rs_out_reg #(.BPC(BPC)) u_out (
        .clk(clk), .rst(rst), .ld(acc), .ready(o_ready),
        .y(c_y), .cb(o_cb), .cr(o_cr), .a(c_a), .c_valid(c_valid),
        .sof(x == '0 && y == '0), .eol(last_x), .eof(last_x && last_y),
        .m_ready(m_ready), .m_valid(m_valid),
        .m_y(m_y), .m_cb(m_cb), .m_cr(m_cr), .m_a(m_a), .m_c_valid(m_c_valid),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );
endmodule
